// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and constants for the multiplexed 7-segment BCD scanner.
package bcd_display_scanner_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Active-high {g,f,e,d,c,b,a} patterns
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

  localparam logic [SEG_W-1:0] SEG_UNLIT_AH = 7'h00;
  localparam logic [SEG_W-1:0] SEG_UNLIT_AL = 7'h7F;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Load/BCD input and segment/anode output bundle of the display scanner.
interface bcd_display_scanner_if #(
  parameter int unsigned DIGITS = 5
) ();
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_number;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (output load, output bcd_number,
                  input  seg,  input  an, input frame_tick);
  modport slave  (input  load, input  bcd_number,
                  output seg,  output an, output frame_tick);
endinterface

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// Combinational nibble to active-high 7-segment pattern; 10..15 show a dash.
module bcd_to_seg7
  import bcd_display_scanner_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (nibble)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner with per-digit dead-time and frame-aligned updates.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned DIGITS         = 5,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_display_scanner_if.slave  bus
);

  localparam int unsigned BCD_W = NIBBLE_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [SEG_W-1:0]  SEG_OFF    = SEG_ACTIVE_LOW ? SEG_UNLIT_AL : SEG_UNLIT_AH;
  localparam logic [DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                frame_wrap;

  logic [BCD_W-1:0]    shadow_q, active_q;
  logic                pending_q;

  logic [NIBBLE_W-1:0] nibble;
  logic [SEG_W-1:0]    dec_seg;
  logic [DIGITS-1:0]   onehot;
  logic                hide;

  logic [SEG_W-1:0]    seg_d;
  logic [DIGITS-1:0]   an_d;
  logic                tick_d;

  // State register: FSM state, slot counter, digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: BLANK for BLANK_CYCLES, SHOW for the rest of the slot
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    frame_wrap = 1'b0;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_BLANK;
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            frame_wrap = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Shadow capture; active only changes at frame wrap so a frame never tears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (bus.load) shadow_q <= bus.bcd_number;
      if (frame_wrap) begin
        if (bus.load)      active_q <= bus.bcd_number;
        else if (pending_q) active_q <= shadow_q;
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nibble = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) nibble = active_q[NIBBLE_W*i +: NIBBLE_W];
    end
  end

  bcd_to_seg7 u_dec (
    .nibble (nibble),
    .seg_c  (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zero_from;

  // zero_from[i]: digit i and every higher digit of active are zero
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (active_q[NIBBLE_W*(DIGITS-1) +: NIBBLE_W] == '0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (active_q[NIBBLE_W*i +: NIBBLE_W] == '0);
    end
    hide = (idx_q != '0) && zero_from[idx_q];
  end
`else
  assign hide = 1'b0;
`endif

  // Output decode from current state; registered below
  always_comb begin
    seg_d  = SEG_OFF;
    an_d   = AN_OFF;
    onehot = DIGITS'(1) << idx_q;
    tick_d = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
    if ((state_q == ST_SHOW) && !hide) begin
      seg_d = SEG_ACTIVE_LOW ? ~dec_seg : dec_seg;
      an_d  = AN_ACTIVE_LOW  ? ~onehot  : onehot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.seg        <= SEG_OFF;
      bus.an         <= AN_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.seg        <= seg_d;
      bus.an         <= an_d;
      bus.frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: frame-position reference model plus directed literal checks.
module tb_bcd_display_scanner;

  localparam int DIGITS = 5;
  localparam int SDIV   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * SDIV;

  logic clk;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  bcd_display_scanner_if #(.DIGITS(DIGITS)) bus ();

  bcd_display_scanner #(
    .DIGITS(DIGITS), .SCAN_DIV(SDIV), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_lut [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Expected {an, seg} for frame position p given displayed word act
  function automatic logic [11:0] model_out(input int p, input logic [19:0] act);
    int d, s;
    logic [19:0] hi;
    logic [4:0]  an_v;
    logic [6:0]  seg_v;
    bit dark;
    d    = p / SDIV;
    s    = p % SDIV;
    hi   = act >> (4 * d);
    dark = (s < BLANK);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && hi == 20'h0) dark = 1'b1;
`endif
    if (dark) begin
      an_v  = 5'h1F;
      seg_v = 7'h7F;
    end else begin
      an_v  = 5'h1F & ~(5'b00001 << d);
      seg_v = ~seg_lut[hi[3:0]];
    end
    return {an_v, seg_v};
  endfunction

  logic [19:0] m_shadow = '0, m_active = '0;
  bit          m_pending = 1'b0;
  int          pos = 0, exp_pos = -1;
  logic [6:0]  exp_seg = 7'h7F;
  logic [4:0]  exp_an = 5'h1F;
  logic        exp_tick = 1'b0;

  // Reference model: pos is the frame position the DUT is about to present
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_shadow <= '0; m_active <= '0; m_pending <= 1'b0;
      pos <= 0; exp_pos <= -1;
      exp_seg <= 7'h7F; exp_an <= 5'h1F; exp_tick <= 1'b0;
    end else begin
      exp_pos  <= pos;
      {exp_an, exp_seg} <= model_out(pos, m_active);
      exp_tick <= (pos == 0);
      pos      <= (pos + 1) % FRAME;
      if (bus.load) m_shadow <= bus.bcd_number;
      if (pos == FRAME - 1) begin
        if (bus.load)       m_active <= bus.bcd_number;
        else if (m_pending) m_active <= m_shadow;
        m_pending <= 1'b0;
      end else if (bus.load) begin
        m_pending <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    compared++;
    if (bus.seg !== exp_seg || bus.an !== exp_an || bus.frame_tick !== exp_tick) begin
      mismatched++;
      $display("FAIL cycle_cmp t=%0t pos=%0d got seg=%h an=%h tick=%b want seg=%h an=%h tick=%b",
               $time, exp_pos, bus.seg, bus.an, bus.frame_tick, exp_seg, exp_an, exp_tick);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_exp(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_pos != p && n < 200);
    if (exp_pos != p) begin
      compared++; mismatched++;
      $display("FAIL wait_exp timeout got pos %0d want %0d", exp_pos, p);
    end
  endtask

  task automatic load_at(input int p, input logic [19:0] v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pos != p && n < 200);
    if (pos != p) begin
      compared++; mismatched++;
      $display("FAIL load_at timeout got pos %0d want %0d", pos, p);
    end
    bus.load = 1'b1;
    bus.bcd_number = v;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  function automatic logic [19:0] rand_bcd();
    logic [19:0] v;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 9) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    bus.load = 1'b0;
    bus.bcd_number = '0;
    repeat (3) @(negedge clk);
    chk("reset_seg", 32'(bus.seg), 32'h7F);
    chk("reset_an", 32'(bus.an), 32'h1F);
    chk("reset_tick", 32'(bus.frame_tick), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("first_tick", 32'(bus.frame_tick), 32'h1);
    chk("first_blank_an", 32'(bus.an), 32'h1F);
    wait_exp(2);
    chk("first_frame_seg", 32'(bus.seg), 32'h40);
    chk("first_frame_an", 32'(bus.an), 32'h1E);

    load_at(10, 20'h12345);
    wait_exp(26);
    chk("no_tear_seg", 32'(bus.seg), 32'h40);
    chk("no_tear_an", 32'(bus.an), 32'h17);
    wait_exp(2);
    chk("d0_5_seg", 32'(bus.seg), 32'h12);
    chk("d0_5_an", 32'(bus.an), 32'h1E);
    wait_exp(34);
    chk("d4_1_seg", 32'(bus.seg), 32'h79);
    chk("d4_1_an", 32'(bus.an), 32'h0F);

    load_at(5, 20'h11111);
    load_at(12, 20'h22222);
    wait_exp(2);
    chk("last_load_wins", 32'(bus.seg), 32'h24);
    load_at(FRAME - 1, 20'h33333);
    wait_exp(2);
    chk("wrap_load_bypass", 32'(bus.seg), 32'h30);

    load_at(10, 20'h0000A);
    wait_exp(2);
    chk("dash_seg", 32'(bus.seg), 32'h3F);
    wait_exp(10);
    chk("zero_d1_seg", 32'(bus.seg), 32'h40);
    chk("zero_d1_an", 32'(bus.an), 32'h1D);

`ifdef LEADING_ZERO_BLANK_EN
    load_at(10, 20'h00042);
    wait_exp(2);
    chk("lzb_d0_seg", 32'(bus.seg), 32'h24);
    wait_exp(10);
    chk("lzb_d1_seg", 32'(bus.seg), 32'h19);
    wait_exp(18);
    chk("lzb_d2_an", 32'(bus.an), 32'h1F);
    chk("lzb_d2_seg", 32'(bus.seg), 32'h7F);
    load_at(10, 20'h00000);
    wait_exp(2);
    chk("lzb_zero_d0", 32'(bus.seg), 32'h40);
    wait_exp(10);
    chk("lzb_zero_d1_an", 32'(bus.an), 32'h1F);
`endif

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bus.load = ($urandom_range(0, 15) == 0);
      bus.bcd_number = rand_bcd();
    end
    @(negedge clk);
    bus.load = 1'b0;

    load_at(10, 20'h98765);
    wait_exp(20);
    chk("pre_reset_an", 32'(bus.an), 32'h1B);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_an", 32'(bus.an), 32'h1F);
    chk("async_reset_seg", 32'(bus.seg), 32'h7F);
    chk("async_reset_tick", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("restart_tick", 32'(bus.frame_tick), 32'h1);
    wait_exp(2);
    chk("restart_active_zero", 32'(bus.seg), 32'h40);
    wait_exp(2);
    chk("restart_pending_clear", 32'(bus.seg), 32'h40);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
